// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file for the ID stage.
//
// Every read port is registered, so data appears one clock after its address
// is sampled. After reset, or when clear_req is pulsed, a hardware sweep
// writes a fill value into every entry. The sweep replaces any
// simulation-only initialisation, and busy stays high while it runs.
//
// Parameters
//   DATA_W    register width
//   ADDR_W    address width; depth = 2**ADDR_W
//   NUM_RD    number of read ports (1..4)
//   ZERO_REG  1: register 0 reads as zero and writes to it are dropped
//   INIT_MODE sweep fill value: 0 = zeros, 1 = register index (zero-extended)
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   we         write enable (ignored while busy)
//   wr_addr    write address
//   wr_data    write data
//   rd_addr    read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    read data, port k at [k*DATA_W +: DATA_W], 1-cycle latency
//   clear_req  one-cycle pulse that restarts the init sweep
//   busy       high while the init sweep runs
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read of the address written in the same
//                      cycle returns the new data (write-first). Otherwise it
//                      returns the old contents (read-first).

module regfile_mp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clear_req,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDR_W-1:0]        idx;
  logic [ADDR_W-1:0]        idx_nxt;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DATA_W-1:0]        fill;
  logic                     wr_ok;
  logic [NUM_RD*DATA_W-1:0] rd_nxt;
  logic [NUM_RD*DATA_W-1:0] rd_data_p1;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Sweep sequencing: INIT walks idx across the whole array, then hands over to RUN.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_INIT: begin
        idx_nxt = idx + 1'b1;
        if (idx == '1) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (clear_req) begin
          state_nxt = S_INIT;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_INIT;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  assign busy = (state == S_INIT);
  assign fill = (INIT_MODE != 0) ? DATA_W'(idx) : '0;

  // A clear_req in the same cycle wins over a user write, so the write is dropped.
  assign wr_ok = (state == S_RUN) && we && !clear_req && !is_zero_reg(wr_addr);

  // Storage is not reset; the sweep defines its contents.
  always_ff @(posedge clock) begin
    if (state == S_INIT) begin
      mem[idx] <= fill;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read select: zero while sweeping, hard zero for r0, optional write bypass.
  always_comb begin
    rd_nxt = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (state == S_RUN && !is_zero_reg(rd_addr[k*ADDR_W +: ADDR_W])) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (rd_addr[k*ADDR_W +: ADDR_W] == wr_addr)) begin
          rd_nxt[k*DATA_W +: DATA_W] = wr_data;
        end else begin
          rd_nxt[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
        end
`else
        rd_nxt[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
`endif
      end
    end
  end

  // Stage p1: registered read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_p1 <= '0;
    end else begin
      rd_data_p1 <= rd_nxt;
    end
  end

  assign rd_data = rd_data_p1;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the pipeline ID stage. It generalises the 32x32 2-read/1-write file in width, depth and read-port count. It adds registered reads with defined latency, an optional write-to-read bypass, and a hardware init sweep after reset or on request. The sweep replaces simulation-only initialisation and reports progress via busy.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hard-wired to zero (reads return 0, writes dropped)
INIT_MODE, 1, sweep fill value: 0 = all zeros, 1 = register i gets value i (zero-extended)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
we  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_addr  input  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
clear_req  input  1  one-cycle pulse: restart init sweep
busy  output  1  high while init sweep runs

Behaviour:
- One clock; reset is asynchronous and active-low: clock is clock, reset is reset_n.
- Reset (reset_n=0): rd_data=0, busy=1, sweep index=0, FSM=INIT. Storage array is not reset directly; the sweep fills it.
- FSM states: INIT, RUN.
- INIT: each cycle writes the fill value to array[idx] and increments idx.
  - Fill value is 0 for INIT_MODE=0, idx for INIT_MODE=1.
  - At idx = 2**ADDR_W-1 the write completes and FSM goes to RUN; busy drops the same edge.
  - The sweep takes exactly 2**ADDR_W cycles after reset_n deasserts.
- INIT constraints: we ignored; rd_data held at 0; clear_req ignored.
- RUN: clear_req=1 -> INIT with idx=0, busy=1 next cycle. A write presented in the same cycle as clear_req is dropped.
- Writes: on posedge, when RUN && we && !(ZERO_REG && wr_addr==0), array[wr_addr] <= wr_data.
- Reads: registered, 1-cycle latency.
  - Port k samples rd_addr[k] at posedge N; data is valid on rd_data[k] after posedge N.
  - ZERO_REG=1 and address 0 -> 0.
- Multiple ports reading the same address all return identical data.
- Address width rules: no truncation; every address is in range by construction. INIT_MODE=1 values are zero-extended from ADDR_W to DATA_W.
- reset_n asserted mid-sweep or mid-operation: immediate return to the reset values; the sweep restarts from 0 after release.
- Same-cycle read and write of the same address: see Optional Feature.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: a read port whose rd_addr equals wr_addr while a write is accepted returns wr_data (write-first). Exception: ZERO_REG address 0 still returns 0.
- Undefined: that port returns the pre-write array contents (read-first). The new value is visible from the next read.
- Both variants: busy and sweep timing are identical; bypass never applies during INIT.

Test Plan:
- Reset release, INIT_MODE=1, defaults: busy high for exactly 32 cycles. Then reading r7 on port0 and r31 on port1 -> 7 and 31 one cycle later.
- Write: we=1, wr_addr=5, wr_data=0xDEADBEEF; next cycle read r5 on both ports -> 0xDEADBEEF on both.
- Zero register: write 0x1234 to r0, then read r0 -> 0. With ZERO_REG=0, the same sequence reads back 0x1234.
- Same-cycle write/read of r9 with 0xA5A5A5A5 (old value 9):
  - REGFILE_BYPASS_EN defined -> 0xA5A5A5A5.
  - Undefined -> 9, then 0xA5A5A5A5 on the following read.
- clear_req pulse after writing r3=0x55: busy high 32 cycles, we ignored throughout; afterwards r3 reads 3 (INIT_MODE=1).
- reset_n pulsed low at sweep idx=10: rd_data=0 and busy=1 immediately; sweep restarts and takes a full 32 cycles; NUM_RD=4 with all ports reading distinct registers returns the correct values.
